pipe_stage_reg: RTL

Parametrised pipeline stage register, the generalised successor to the fixed IF/ID latch, for use between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one opaque payload word with a valid bit.
- Adds a ready/valid handshake and a 2-entry skid buffer, so backpressure does not form a combinational ready path across the stage.
- Keeps the global hazard-unit stall/flush vector semantics: hold on own stall, bubble on upstream stall, clear on flush.

---
 rtl/pipe_stage_reg.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with a ready/valid handshake,
// a 2-entry skid buffer (main + skid) and hazard-unit stall/flush vector control.
//
// The stage sits between any two pipeline stages. Because up_ready is decoded
// from registered state only, downstream backpressure never reaches upstream
// through a combinational path.
//
// Optional feature: define PIPE_STAGE_PERF_EN to add the saturating performance
// counters hold_cnt and bubble_cnt. With the macro undefined, those ports and
// counters do not exist and the rest of the stage behaves the same.

module pipe_stage_reg #(
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       VEC_W      = 5,
  parameter int unsigned       HERE_IDX   = 1,
  parameter int unsigned       UP_IDX     = 0,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  input  logic [VEC_W-1:0]  stall,
  input  logic [VEC_W-1:0]  flush,
`ifdef PIPE_STAGE_PERF_EN
  output logic [31:0]       hold_cnt,
  output logic [31:0]       bubble_cnt,
`endif
  output logic [1:0]        occ
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  // Registered-state decodes shared by control and outputs.
  logic valid_int;
  logic ready_int;

  // Hazard-unit controls owned by this stage.
  logic hold;
  logic bubble;
  logic flush_here;

  // Handshake events.
  logic adv;
  logic acc;

  // Only the owned stall/flush bits matter; the rest are deliberately ignored.
  logic unused_vec_bits;
  assign unused_vec_bits = ^{stall, flush};

  // Derive hold/bubble/flush from the owned vector bits.
  always_comb begin
    hold       = stall[HERE_IDX];
    flush_here = flush[HERE_IDX];
    bubble     = 1'b0;
    if (HERE_IDX > 0) begin
      bubble = stall[UP_IDX] && !hold;
    end
  end

  // Registered-state decodes and handshake events.
  always_comb begin
    valid_int = (state_q != StEmpty);
    ready_int = (state_q != StTwo);
    adv       = valid_int && dn_ready && !hold;
    // A bubble drops the upstream word; upstream keeps its own copy.
    acc       = up_valid && ready_int && !bubble && !hold;
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StEmpty;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and payload movement; flush overrides everything.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_here) begin
      state_d = StEmpty;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else if (!hold) begin
      unique case (state_q)
        StEmpty: begin
          if (acc) begin
            state_d = StOne;
            main_d  = up_data;
          end
        end
        StOne: begin
          if (acc && adv) begin
            main_d = up_data;
          end else if (acc) begin
            state_d = StTwo;
            skid_d  = up_data;
          end else if (adv) begin
            state_d = StEmpty;
            main_d  = BUBBLE_VAL;
          end
        end
        StTwo: begin
          // up_ready is low here, so only a pop can occur.
          if (adv) begin
            state_d = StOne;
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  // Outputs come straight from registered state.
  always_comb begin
    dn_valid = valid_int;
    up_ready = ready_int;
    dn_data  = main_q;
    occ      = state_q;
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating increments; flush intentionally leaves the counters alone.
  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (hold && valid_int && (hold_cnt_q != 32'hFFFF_FFFF)) begin
      hold_cnt_d = hold_cnt_q + 32'd1;
    end
    if (bubble && up_valid && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt_q   <= '0;
      bubble_cnt_q <= '0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Counter outputs.
  always_comb begin
    hold_cnt   = hold_cnt_q;
    bubble_cnt = bubble_cnt_q;
  end
`endif

endmodule
